// File: rtl/sprite_pkg.sv
// sprite_pkg: OAM word layout, secondary-array entry, sprite height and evaluator states
// shared by sprite_evaluator and sprite_drawer.
package sprite_pkg;
    localparam int SPRITE_HEIGHT = 16;
    typedef struct packed {
        logic       enable;
        logic       yflip;
        logic       xflip;
        logic       prio;
        logic [9:0] ypos;
        logic [9:0] xpos;
        logic [7:0] spriteref;
    } oam_entry_t;
    typedef struct packed {
        logic [7:0] addr;
        logic       valid;
    } second_entry_t;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} eval_state_t;
endpackage

// File: rtl/sprite_y_match.sv
// sprite_y_match: combinational range hit test; 11-bit unsigned compare so a large
// position never wraps onto a small line.
module sprite_y_match import sprite_pkg::*; #(
    parameter int LINE_W = 9,
    parameter int HEIGHT = SPRITE_HEIGHT
) (
    input  logic              enable,
    input  logic [9:0]        ypos,
    input  logic [LINE_W-1:0] line,
    output logic              hit
);
    logic [10:0] l, y, d;
    always_comb begin
        l   = 11'(line);
        y   = 11'(ypos);
        d   = l - y;
        hit = enable && (l >= y) && (d < 11'(HEIGHT));
    end
endmodule

// File: rtl/sprite_evaluator.sv
// sprite_evaluator: scans every OAM entry for one line and fills the secondary array
// with the addresses of sprites covering it, evaluating one cycle behind the address.
module sprite_evaluator import sprite_pkg::*; #(
    parameter int OAM_ADDR_SIZE     = 8,
    parameter int OAM_DATA_SIZE     = 32,
    parameter int SECOND_ARRAY_SIZE = 32,
    parameter int SPRITE_HEIGHT     = sprite_pkg::SPRITE_HEIGHT,
    parameter int DISPLAY_HEIGHT    = 480,
    parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [LINE_NUMBER_WIDTH-1:0]                  line_number,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          overflow,
    output logic                                          oam_req,
    output logic [OAM_ADDR_SIZE-1:0]                      oam_a,
    input  logic [OAM_DATA_SIZE-1:0]                      oam_d,
    output logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0] second_array
);
    localparam int SW = $clog2(SECOND_ARRAY_SIZE);
    localparam logic [OAM_ADDR_SIZE-1:0] LAST = '1;

    eval_state_t state, next;
    logic [OAM_ADDR_SIZE-1:0]     idx, idx_q;
    logic [LINE_NUMBER_WIDTH-1:0] line_q;
    logic [SW:0]                  count;
    logic                         eval_v, hit, eval, full, unused;
    oam_entry_t                   e;

    assign e      = oam_d[31:0];
    assign unused = ^{e.spriteref, e.xpos, e.prio, e.xflip, e.yflip};

    sprite_y_match #(.LINE_W(LINE_NUMBER_WIDTH), .HEIGHT(SPRITE_HEIGHT)) u_y (
        .enable (e.enable),
        .ypos   (e.ypos),
        .line   (line_q),
        .hit    (hit)
    );

    // eval_v marks that oam_d holds the word addressed last cycle
    assign eval = eval_v && (state == SCAN || state == DRAIN) && hit;
    assign full = count == (SW+1)'(SECOND_ARRAY_SIZE);

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? SCAN : IDLE;
            SCAN:    next = (eval && full) ? DONE : (idx == LAST) ? DRAIN : SCAN;
            DRAIN:   next = DONE;
            default: next = IDLE;
        endcase
        busy    = state == SCAN || state == DRAIN;
        done    = state == DONE;
        oam_req = state == SCAN;
        oam_a   = idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            idx_q        <= '0;
            eval_v       <= 1'b0;
            line_q       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            second_array <= '0;
        end else begin
            state  <= next;
            eval_v <= state == SCAN;
            idx_q  <= idx;
            if (state == SCAN)
                idx <= idx + 1'b1;
            if (state == IDLE && start) begin
                idx          <= '0;
                line_q       <= line_number;
                count        <= '0;
                overflow     <= 1'b0;
                second_array <= '0;
            end
            if (eval && !full) begin
                second_array[count[SW-1:0]] <= {idx_q, 1'b1};
                count                       <= count + 1'b1;
            end
            if (eval && full)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sprite_evaluator.sv
// tb_sprite_evaluator: directed scans against a bench-held OAM; expected completions
// are queued by the stimulus and checked by a monitor on each done pulse.
module tb_sprite_evaluator;
    logic                  clk = 0, rst = 1, start = 0;
    logic [8:0]            line_number = '0;
    logic                  busy, done, overflow, oam_req;
    logic [7:0]            oam_a;
    logic [31:0]           oam_d;
    logic [31:0][8:0]      second_array;
    logic [31:0]           oam [256];

    typedef struct {
        int               t_done;
        logic [31:0][8:0] arr;
        logic             ovf;
    } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0, ecnt = 0, t0 = 0;
    logic [31:0][8:0] ea;

    sprite_evaluator dut (
        .clk(clk), .rst(rst), .start(start), .line_number(line_number),
        .busy(busy), .done(done), .overflow(overflow), .oam_req(oam_req),
        .oam_a(oam_a), .oam_d(oam_d), .second_array(second_array)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;
    always @(posedge clk) oam_d <= oam[oam_a];

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor: observed at negedge, so the current cycle number is ecnt+1
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 288'(ecnt + 1), 288'(0));
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("done_cycle", 288'(ecnt + 1), 288'(x.t_done));
                chk("array", second_array, x.arr);
                chk("overflow", 288'(overflow), 288'(x.ovf));
                chk("oam_req_at_done", 288'(oam_req), 288'(0));
                chk("busy_at_done", 288'(busy), 288'(0));
            end
        end
    end

    function automatic logic [31:0] mk(input logic en, input logic [9:0] y);
        return {en, 3'b101, y, 10'h155, 8'hA5};
    endfunction

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) oam[i] = mk(1'b0, 10'd100);
    endtask

    task automatic go(input logic [8:0] ln, input int off, input logic [31:0][8:0] arr,
                      input logic ovf, input logic push);
        @(negedge clk);
        start       = 1;
        line_number = ln;
        t0          = ecnt + 1;
        if (push) q.push_back('{t0 + off, arr, ovf});
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 288'(q.size()), 288'(0));
            q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_oam();
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_busy", 288'(busy), 288'(0));
        chk("rst_done", 288'(done), 288'(0));
        chk("rst_overflow", 288'(overflow), 288'(0));
        chk("rst_oam_req", 288'(oam_req), 288'(0));
        chk("rst_oam_a", 288'(oam_a), 288'(0));
        chk("rst_array", second_array, 288'(0));

        go(9'd100, 258, '0, 1'b0, 1'b1);
        chk("busy_after_start", 288'(busy), 288'(1));
        chk("oam_req_after_start", 288'(oam_req), 288'(1));
        wait_idle();

        oam[3] = mk(1'b1, 10'd100);
        oam[7] = mk(1'b1, 10'd85);
        oam[9] = mk(1'b1, 10'd84);
        oam[5] = mk(1'b0, 10'd100);
        oam[6] = mk(1'b1, 10'd1020);
        ea = '0;
        ea[0] = {8'd3, 1'b1};
        ea[1] = {8'd7, 1'b1};
        go(9'd100, 258, ea, 1'b0, 1'b1);
        wait_idle();
        chk("array_stable_after_done", second_array, ea);

        go(9'd3, 258, '0, 1'b0, 1'b1);
        wait_idle();

        clear_oam();
        for (int i = 0; i <= 32; i++) oam[i] = mk(1'b1, 10'd0);
        ea = '0;
        for (int i = 0; i < 32; i++) ea[i] = {8'(i), 1'b1};
        go(9'd0, 35, ea, 1'b1, 1'b1);
        wait_idle();
        chk("overflow_held", 288'(overflow), 288'(1));

        clear_oam();
        oam[3] = mk(1'b1, 10'd100);
        oam[7] = mk(1'b1, 10'd85);
        go(9'd100, 0, '0, 1'b0, 1'b0);
        repeat (48) @(negedge clk);
        chk("array_filled_midscan", second_array[1:0], 288'({9'h00F, 9'h007}));
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_busy", 288'(busy), 288'(0));
        chk("abort_oam_req", 288'(oam_req), 288'(0));
        chk("abort_array", second_array, 288'(0));
        repeat (300) @(negedge clk);

        ea = '0;
        ea[0] = {8'd3, 1'b1};
        ea[1] = {8'd7, 1'b1};
        go(9'd100, 258, ea, 1'b0, 1'b1);
        wait_idle();

        go(9'd100, 258, ea, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        line_number = 9'd0;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_idle();
        repeat (300) @(negedge clk);
        chk("queue_drained", 288'(q.size()), 288'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_evaluator.md
# sprite_evaluator

Per-scanline sprite evaluation: on `start`, scans all OAM entries, selects enabled sprites whose 16-row vertical span covers the given line, and fills the secondary array (OAM addresses plus valid bit) consumed by `sprite_drawer` for the same line. It sits between OAM and `sprite_drawer` in the sprite pipeline and runs during the preceding line, so the array is complete before drawing starts.

## Interface
Parameters:
- `OAM_ADDR_SIZE`, 8: OAM address width; number of OAM entries scanned is 2**OAM_ADDR_SIZE.
- `OAM_DATA_SIZE`, 32: OAM word width.
- `SECOND_ARRAY_SIZE`, 32: maximum sprites per line.
- `SPRITE_HEIGHT`, 16: sprite rows.
- `DISPLAY_HEIGHT`, 480: visible lines.
- `LINE_NUMBER_WIDTH`, $clog2(DISPLAY_HEIGHT): line number width.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request to evaluate `line_number`.
- `line_number`  in  LINE_NUMBER_WIDTH  line to evaluate; sampled on the `start` cycle.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse; array is final.
- `overflow`  out  1  more than SECOND_ARRAY_SIZE sprites hit this line; held until next accepted `start`.
- `oam_req`  out  1  high while `oam_a` is valid; external mux grants the OAM bus.
- `oam_a`  out  OAM_ADDR_SIZE  OAM read address.
- `oam_d`  in  OAM_DATA_SIZE  OAM read data; synchronous RAM, one-cycle latency.
- `second_array`  out  [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0]  bits [OAM_ADDR_SIZE:1] are the OAM address, bit [0] is valid.

## Operation
- OAM word layout: [7:0] spriteref, [17:8] xpos, [27:18] ypos, [28] priority, [29] xflip, [30] yflip, [31] enable.
- States:
  - IDLE: `start` accepted; latch `line_number`; clear all valid bits, `count`, and `overflow`; go to SCAN.
  - SCAN: `oam_a` = `idx`, with `idx` counting 0..2**OAM_ADDR_SIZE-1, one address per cycle and `oam_req`=1. After the last address, go to DRAIN.
  - DRAIN: one cycle to evaluate the final returned word; `oam_req`=0; go to DONE.
  - DONE: `done`=1 for one cycle; go to IDLE.
- Evaluation runs one cycle behind the address, using the registered address `idx_q`. A hit requires all of:
  - enable bit = 1;
  - line ≥ ypos;
  - (line − ypos) < SPRITE_HEIGHT.
- Compare width: compute in 11-bit unsigned with line zero-extended, so there is no wrap-around. A sprite at ypos 1020 never hits line 3.
- On a hit with `count` < SECOND_ARRAY_SIZE: write `{idx_q, 1'b1}` to `second_array[count]` and increment `count`.
- On a hit with `count` == SECOND_ARRAY_SIZE: set `overflow`, stop issuing addresses, and go straight to DONE. Remaining entries are not scanned.
- Entries are written in ascending OAM address order. Unwritten slots stay 0, so the first invalid slot terminates `sprite_drawer`'s walk.
- `second_array` is stable from `done` until the next accepted `start`.
- `start` is ignored while `busy`.

## Timing
- Reset values: `busy`=0, `done`=0, `overflow`=0, `oam_req`=0, `oam_a`=0, `second_array`=all 0; state IDLE.
- `rst` mid-scan aborts on the next edge; all outputs return to reset values.
- Let `start` be sampled at edge T0, and N = 2**OAM_ADDR_SIZE.
  - Addresses 0..N-1 are presented in cycles T0+1..T0+N.
  - Entry k is evaluated at the edge ending cycle T0+k+2.
  - Without overflow, `done` is high during cycle T0+N+2 (258 cycles after start for N=256).
  - `busy` is high during T0+1..T0+N+1.
- Overflow: if the overflowing hit is entry k, `done` is high during cycle T0+k+3, and `oam_req` drops in that same cycle.
- `start` asserted in the same cycle as `done` is ignored. It is accepted from the next cycle.

## Structure
- Shared package `sprite_pkg`:
  - `oam_entry_t` packed struct in the layout above;
  - `second_entry_t`;
  - `SPRITE_HEIGHT`;
  - state enum `eval_state_t`.
- `sprite_drawer` adopts the same package.
- Sub-module `sprite_y_match`: combinational hit test (enable, ypos, line → hit), reused later for the x-range test.

## Test plan
- OAM all disabled, line 100 → `done` at T0+258; `second_array` all 0; `overflow`=0.
- Entries 3 (ypos 100), 7 (ypos 85), 9 (ypos 84), all enabled, line 100 → slot 0 = {3,1}, slot 1 = {7,1}; entry 9 misses because 100−84 = 16; slot 2 valid=0.
- Entry 5 with ypos 100 but enable=0, line 100 → not selected. Entry 6 with ypos 1020, line 3 → not selected.
- 33 enabled sprites at ypos 0 in entries 0..32, line 0 → slots 0..31 = addresses 0..31; `overflow`=1; `done` at T0+35; `oam_req` low in that cycle.
- `rst` pulsed at T0+50 of a scan → next cycle: `busy`=0, `second_array`=0. A fresh `start` then completes normally.
- Second `start` at T0+10 while busy → ignored; exactly one `done` pulse at T0+258.
